cvxif_core_initiator: RTL

// Core-side (initiator) end of the CoreV-X-Interface v1.0.0 issue/register/commit/result channels.

---
 rtl/cvxif_core_initiator.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/cvxif_core_initiator.sv
// Core-side initiator for the CV-X-IF issue/register/commit/result channels.
// One offload in flight through issue/register/commit at a time; multiple
// committed offloads may await results, tracked by an id bitmap and a count.
module cvxif_core_initiator #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned ID_WIDTH        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  // core-side offload stream
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  input  logic [XLEN-1:0]     rs1,
  input  logic [XLEN-1:0]     rs2,
  // issue channel
  output logic                issue_valid,
  output logic [31:0]         issue_instr,
  output logic [ID_WIDTH-1:0] issue_id,
  input  logic                issue_ready,
  input  logic                issue_accept,
  // register channel
  output logic                register_valid,
  output logic [ID_WIDTH-1:0] register_id,
  output logic [XLEN-1:0]     register_rs1,
  output logic [XLEN-1:0]     register_rs2,
  input  logic                register_ready,
  // commit channel
  output logic                commit_valid,
  output logic [ID_WIDTH-1:0] commit_id,
  output logic                commit_kill,
  // result channel
  input  logic                result_valid,
  output logic                result_ready,
  input  logic [ID_WIDTH-1:0] result_id,
  input  logic [4:0]          result_rd,
  input  logic                result_we,
  input  logic [XLEN-1:0]     result_data,
  // core writeback and status
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic                reject,
  output logic                err_unexpected_id
);

  localparam int unsigned NUM_IDS = 2 ** ID_WIDTH;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW      = 32;
  localparam int unsigned RD_W    = 5;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, REGISTER, COMMIT} state_e;

  state_e                state_q;
  logic [ID_WIDTH-1:0]   next_id_q, next_id_d;
  logic [NUM_IDS-1:0]    bitmap_q, bitmap_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  instr_ready_q;
  logic                  issue_valid_q;
  logic                  register_valid_q;
  logic                  commit_valid_q;
  logic                  commit_kill_q;
  logic                  reject_q;
  logic [IW-1:0]         instr_q;
  logic [XLEN-1:0]       rs1_q, rs2_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  wb_valid_q;
  logic [RD_W-1:0]       wb_rd_q;
  logic [XLEN-1:0]       wb_data_q;
  logic                  err_q;
  logic                  result_ready_q;

  logic                  res_hs, res_known, commit_set, offload_hs, goes_idle, slot_free;

  // Next outstanding-id state: commit sets, known result clears, both may coincide
  always_comb begin
    res_hs     = result_valid && result_ready_q;
    res_known  = res_hs && bitmap_q[result_id];
    commit_set = commit_valid_q && !commit_kill_q;
    offload_hs = (state_q == IDLE) && instr_valid && instr_ready_q;
    bitmap_d   = bitmap_q;
    count_d    = count_q;
    if (commit_set) bitmap_d[id_q] = 1'b1;
    if (res_known)  bitmap_d[result_id] = 1'b0;
    if (commit_set && !res_known)      count_d = count_q + CNT_W'(1);
    else if (!commit_set && res_known) count_d = count_q - CNT_W'(1);
    next_id_d  = (state_q == COMMIT) ? next_id_q + ID_WIDTH'(1) : next_id_q;
    goes_idle  = ((state_q == IDLE) && !offload_hs) || (state_q == COMMIT);
    slot_free  = !bitmap_d[next_id_d] && (count_d < MAX_CNT);
  end

  // Offload FSM with registered channel outputs and latched payload
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      next_id_q        <= '0;
      instr_ready_q    <= 1'b0;
      issue_valid_q    <= 1'b0;
      register_valid_q <= 1'b0;
      commit_valid_q   <= 1'b0;
      commit_kill_q    <= 1'b0;
      reject_q         <= 1'b0;
      instr_q          <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      id_q             <= '0;
    end else begin
      commit_valid_q <= 1'b0;
      commit_kill_q  <= 1'b0;
      reject_q       <= 1'b0;
      instr_ready_q  <= goes_idle && slot_free;
      next_id_q      <= next_id_d;
      case (state_q)
        IDLE: begin
          if (offload_hs) begin
            state_q       <= ISSUE;
            instr_q       <= instr;
            rs1_q         <= rs1;
            rs2_q         <= rs2;
            id_q          <= next_id_q;
            issue_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            issue_valid_q <= 1'b0;
            if (issue_accept) begin
              state_q          <= REGISTER;
              register_valid_q <= 1'b1;
            end else begin
              state_q        <= COMMIT;
              commit_valid_q <= 1'b1;
              commit_kill_q  <= 1'b1;
              reject_q       <= 1'b1;
            end
          end
        end
        REGISTER: begin
          if (register_ready) begin
            register_valid_q <= 1'b0;
            state_q          <= COMMIT;
            commit_valid_q   <= 1'b1;
          end
        end
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outstanding tracking, result acceptance and core writeback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitmap_q       <= '0;
      count_q        <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      err_q          <= 1'b0;
      result_ready_q <= 1'b0;
    end else begin
      bitmap_q       <= bitmap_d;
      count_q        <= count_d;
      result_ready_q <= 1'b1;
      wb_valid_q     <= res_known && result_we;
      if (res_known) begin
        wb_rd_q   <= result_rd;
        wb_data_q <= result_data;
      end
      if (res_hs && !res_known) err_q <= 1'b1;
    end
  end

  assign instr_ready       = instr_ready_q;
  assign issue_valid       = issue_valid_q;
  assign issue_instr       = instr_q;
  assign issue_id          = id_q;
  assign register_valid    = register_valid_q;
  assign register_id       = id_q;
  assign register_rs1      = rs1_q;
  assign register_rs2      = rs2_q;
  assign commit_valid      = commit_valid_q;
  assign commit_id         = id_q;
  assign commit_kill       = commit_kill_q;
  assign result_ready      = result_ready_q;
  assign wb_valid          = wb_valid_q;
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign reject            = reject_q;
  assign err_unexpected_id = err_q;

endmodule
